uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit side of the serial link: buffers bytes written by the CPU in a small FIFO and serialises them as 8N1 frames on a single line.
- Line format is idle-high, start bit 0, 8 data bits LSB first, stop bit 1.
- Bit period is CLK_DIV clock cycles, identical to the receiver's divider. A tx_out looped back to the receiver's uart_in returns the written bytes.

Parameters:
- CLK_DIV, 10: clocks per bit. Legal range 2..255.
- FIFO_AW, 2: FIFO address width. Depth = 2**FIFO_AW = 4 entries.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- cpu_data  input  8  byte to transmit.
- cpu_write  input  1  write strobe, sampled on posedge clk; 1-cycle pulse per byte.
- fifo_full  output  1  FIFO holds 2**FIFO_AW bytes; writes are dropped.
- fifo_empty  output  1  no bytes queued. A byte being shifted out does not count as queued.
- tx_busy  output  1  a frame is on the line (any state except IDLE).
- tx_done  output  1  1-cycle pulse on the last cycle of each stop bit.
- tx_out  output  1  serial line.

Behaviour:
- Reset, one clock and reset: clk plus asynchronous, active-high rst. While rst=1:
  - tx_out=1, tx_busy=0, tx_done=0, fifo_full=0, fifo_empty=1.
  - FIFO pointers, count, bit counter and divider all clear to 0.
  - State goes to IDLE.
  - Reset mid-frame aborts the frame: tx_out goes to 1 asynchronously and queued bytes are discarded.
- FIFO:
  - Write pointer wp, read pointer rp (FIFO_AW bits, wrap modulo depth) and count (FIFO_AW+1 bits).
  - fifo_full = (count == depth); fifo_empty = (count == 0). Both are registered and updated on the same edge as count.
  - Push: cpu_write=1 and fifo_full=0 at the edge. mem[wp] <= cpu_data, wp <= wp+1.
  - cpu_write while fifo_full=1 is ignored. No error flag; data is lost. This holds even if a pop occurs on the same edge, because full is evaluated before the edge.
  - Pop: happens only in IDLE when fifo_empty=0. shift_reg <= mem[rp], rp <= rp+1.
  - Push and pop on the same edge leave count unchanged; both pointers advance.
- State machine:
  - IDLE:
    - tx_out=1.
    - If !fifo_empty: pop, clear divider and bit counter, go to START.
    - A byte pushed into an empty FIFO at edge N is popped at edge N+1; tx_out falls after edge N+1.
  - START:
    - tx_out=0 for exactly CLK_DIV cycles.
    - On divider = CLK_DIV-1: go to DATA, divider <= 0.
  - DATA:
    - tx_out = shift_reg[0].
    - On divider = CLK_DIV-1: shift_reg >>= 1, bit_cnt += 1.
    - After bit_cnt reaches 7 and its period ends, go to STOP.
    - Each data bit lasts exactly CLK_DIV cycles.
  - STOP:
    - tx_out=1 for CLK_DIV cycles.
    - tx_done=1 on the final cycle (divider = CLK_DIV-1).
    - Then go to IDLE.
- Back-to-back frames:
  - IDLE lasts exactly 1 cycle if the FIFO is non-empty.
  - Frame period is therefore 10*CLK_DIV+1 cycles.
  - The extra idle-high cycle is required; it re-arms the receiver's start detection.
- tx_out is driven from a register (no combinational glitches). Its value changes only at bit boundaries.
- cpu_data and cpu_write may change at any cycle. Frame content depends only on cpu_data sampled at the push edge.

Test Plan:
- Single byte, CLK_DIV=10:
  - Stimulus: push 0xA5 at edge 0.
  - Required: tx_out=0 during cycles 2..11, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high for 10 cycles.
  - Required: tx_done pulses once at cycle 101; tx_busy=0 at cycle 102; fifo_empty=1 from cycle 2.
- Fill FIFO:
  - Stimulus: push 0x01..0x05 on 5 consecutive cycles.
  - Required: 0x01 is popped at edge 1, so 0x02..0x05 fill the FIFO; fifo_full=1 after edge 4.
  - Stimulus: a 6th write (0x06) at edge 5.
  - Required: 0x06 is dropped; line emits 01,02,03,04,05 with 101-cycle frame spacing.
- Full with pop: FIFO full while in IDLE; write 0x77 on the same edge as the pop -> 0x77 is rejected and count becomes 3.
- Reset mid-frame: assert rst during data bit 3 of 0x3C with 2 bytes queued -> tx_out=1 immediately; after release, no frame is emitted until a new write.
- Loopback:
  - Stimulus: tx_out wired to receiver uart_in, both CLK_DIV=10, random 64 bytes pushed with full-respecting writes.
  - Required: the receiver's read_int fires 64 times with identical bytes in order.
- CLK_DIV=2 corner: push 0xFF -> frame is 20 cycles. tx_out shows 2 low cycles, then 18 high cycles, and no glitch at state transitions.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: the CPU pushes bytes, the line emits
// 8N1 frames (idle high, start 0, 8 data bits LSB first, stop 1).
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_data,
    input  logic       cpu_write,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_out
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]         mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wp;
    logic [FIFO_AW-1:0] rp;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_n;
    logic               push;
    logic               pop;

    logic [1:0] state;
    logic [1:0] state_n;
    logic [7:0] div;
    logic [7:0] div_n;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    logic [7:0] shift_reg;
    logic [7:0] shift_n;
    logic       tx_out_n;
    logic       tx_done_n;
    logic       tx_busy_n;

    // Full is the pre-edge registered flag, so a same-edge pop never frees room for a write.
    assign push    = cpu_write && !fifo_full;
    assign count_n = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= cpu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push) begin
                wp <= wp + FIFO_AW'(1);
            end
            if (pop) begin
                rp <= rp + FIFO_AW'(1);
            end
            count      <= count_n;
            fifo_full  <= (count_n == CW'(DEPTH));
            fifo_empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b1;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            tx_out    <= tx_out_n;
            tx_done   <= tx_done_n;
            tx_busy   <= tx_busy_n;
        end
    end

    // Line value is computed for the next cycle so tx_out stays a clean register.
    always_comb begin
        state_n   = state;
        div_n     = div;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        tx_out_n  = tx_out;
        tx_done_n = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_out_n = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_n   = mem[rp];
                    div_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = S_START;
                    tx_out_n  = 1'b0;
                end
            end
            S_START: begin
                if (div == DIV_LAST) begin
                    div_n    = '0;
                    state_n  = S_DATA;
                    tx_out_n = shift_reg[0];
                end else begin
                    div_n = div + 8'd1;
                end
            end
            S_DATA: begin
                if (div == DIV_LAST) begin
                    div_n     = '0;
                    shift_n   = shift_reg >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n  = S_STOP;
                        tx_out_n = 1'b1;
                    end else begin
                        tx_out_n = shift_reg[1];
                    end
                end else begin
                    div_n = div + 8'd1;
                end
            end
            S_STOP: begin
                tx_done_n = (div == DIV_PRE);
                if (div == DIV_LAST) begin
                    div_n    = '0;
                    state_n  = S_IDLE;
                    tx_out_n = 1'b1;
                end else begin
                    div_n = div + 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        tx_busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (CLK_DIV 10 and 2) checked every cycle
// against a queue/frame-position model of the line, flags and FIFO occupancy.
module tb_uart_tx_fifo;

    localparam int DIV_A = 10;
    localparam int DIV_B = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] cpu_data;
    logic       cpu_write;
    logic       full_a, empty_a, busy_a, done_a, tx_a;
    logic       full_b, empty_b, busy_b, done_b, tx_b;

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Model: FIFO contents plus position inside the current frame (-1 = idle).
    int         divs [2];
    int         mpos [2];
    logic [7:0] mcur [2];
    logic [7:0] mbuf [2][DEPTH];
    int         mhead [2];
    int         mcnt [2];
    int         accepted0 = 0;

    uart_tx_fifo #(.CLK_DIV(DIV_A), .FIFO_AW(2)) dut_a (
        .clk(clk), .rst(rst), .cpu_data(cpu_data), .cpu_write(cpu_write),
        .fifo_full(full_a), .fifo_empty(empty_a), .tx_busy(busy_a),
        .tx_done(done_a), .tx_out(tx_a)
    );

    uart_tx_fifo #(.CLK_DIV(DIV_B), .FIFO_AW(2)) dut_b (
        .clk(clk), .rst(rst), .cpu_data(cpu_data), .cpu_write(cpu_write),
        .fifo_full(full_b), .fifo_empty(empty_b), .tx_busy(busy_b),
        .tx_done(done_b), .tx_out(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mpos[u]  = -1;
            mhead[u] = 0;
            mcnt[u]  = 0;
        end
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] d);
        for (int u = 0; u < 2; u++) begin
            bit full_pre;
            full_pre = (mcnt[u] == DEPTH);
            if (mpos[u] >= 0) begin
                mpos[u]++;
                if (mpos[u] == 10 * divs[u]) mpos[u] = -1;
            end else if (mcnt[u] > 0) begin
                mcur[u]  = mbuf[u][mhead[u]];
                mhead[u] = (mhead[u] + 1) % DEPTH;
                mcnt[u]--;
                mpos[u]  = 0;
            end
            if (wr && !full_pre) begin
                mbuf[u][(mhead[u] + mcnt[u]) % DEPTH] = d;
                mcnt[u]++;
                if (u == 0) accepted0++;
            end
        end
    endtask

    // Expected {tx_out, tx_busy, tx_done, fifo_full, fifo_empty}.
    function automatic logic [7:0] expect_of(input int u);
        int   p;
        int   idx;
        logic line;
        p = mpos[u];
        if (p < 0) begin
            line = 1'b1;
        end else begin
            idx = p / divs[u];
            if (idx == 0)      line = 1'b0;
            else if (idx <= 8) line = mcur[u][idx-1];
            else               line = 1'b1;
        end
        return {3'b000, line, (p >= 0), (p == 10 * divs[u] - 1),
                (mcnt[u] == DEPTH), (mcnt[u] == 0)};
    endfunction

    task automatic compare_all();
        check({phase, "/div10"}, {3'b000, tx_a, busy_a, done_a, full_a, empty_a}, expect_of(0));
        check({phase, "/div2"},  {3'b000, tx_b, busy_b, done_b, full_b, empty_b}, expect_of(1));
    endtask

    task automatic step(input logic wr, input logic [7:0] d);
        cpu_write = wr;
        cpu_data  = d;
        @(posedge clk);
        model_edge(wr, d);
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    initial begin
        bit found;
        int budget;
        divs[0] = DIV_A;
        divs[1] = DIV_B;
        model_reset();
        rst       = 1'b1;
        cpu_write = 1'b0;
        cpu_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        phase = "reset";
        compare_all();
        rst = 1'b0;

        phase = "single_a5";
        step(1'b1, 8'hA5);
        idle_steps(110);

        phase = "fill";
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        idle_steps(560);

        // Wait for the idle cycle with a full FIFO, then write on the pop edge.
        phase = "full_pop";
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i));
        found = 1'b0;
        for (budget = 0; budget < 300 && !found; budget++) begin
            if (mpos[0] < 0 && mcnt[0] == DEPTH) found = 1'b1;
            else step(1'b0, 8'h00);
        end
        check("full_pop_wait", 8'(found), 8'd1);
        step(1'b1, 8'h77);
        idle_steps(500);

        phase = "reset_mid";
        step(1'b1, 8'h3C);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        found = 1'b0;
        for (budget = 0; budget < 200 && !found; budget++) begin
            if (mpos[0] >= 4 * DIV_A && mpos[0] < 5 * DIV_A) found = 1'b1;
            else step(1'b0, 8'h00);
        end
        check("reset_mid_wait", 8'(found), 8'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        idle_steps(120);

        phase = "loopback";
        accepted0 = 0;
        for (budget = 0; budget < 20000 && accepted0 < 64; budget++) begin
            step((mcnt[0] < DEPTH) && ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        check("loopback_count", 8'(accepted0), 8'd64);
        idle_steps(560);

        phase = "random_drop";
        for (int i = 0; i < 400; i++) step($urandom_range(0, 1) == 1, 8'($urandom));
        idle_steps(560);

        phase = "div2_ff";
        step(1'b1, 8'hFF);
        idle_steps(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
